// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM state encoding and the
// row-count helper used to size table-wide vectors.
package truth_table_scanner_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of truth-table rows for an n_vars-input function.
  function automatic int unsigned rows(input int unsigned n_vars);
    return 32'd1 << n_vars;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Bundle between the scanner (master) and the surrounding lab logic (slave).
// Carries the start request, the stimulus vector, the sampled function output
// and the assembled results. With TRUTH_TABLE_SCANNER_COMPARE_EN defined it
// also carries the expected table and the mismatch/pass results.
interface truth_table_scanner_if
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned N_VARS = 4
);
  localparam int unsigned ROWS = rows(N_VARS);

  logic              start;
  logic [N_VARS-1:0] vec;
  logic              s;
  logic              busy;
  logic              done;
  logic [ROWS-1:0]   table_out;
  logic [N_VARS:0]   ones;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
  logic [ROWS-1:0]   expected;
  logic [ROWS-1:0]   mismatch;
  logic              pass;

  modport master (input start, s, expected,
                  output vec, busy, done, table_out, ones, mismatch, pass);
  modport slave  (output start, s, expected,
                  input vec, busy, done, table_out, ones, mismatch, pass);
`else
  modport master (input start, s,
                  output vec, busy, done, table_out, ones);
  modport slave  (output start, s,
                  input vec, busy, done, table_out, ones);
`endif

endinterface

// File: rtl/truth_table_scanner_settle.sv
// settle_counter: modulo-SETTLE counter that raises strobe_c on the last
// cycle of each hold period. clr holds it at zero (synchronous).
// Ports: clk, reset (sync, active-high), clr, strobe_c (combinational).
module settle_counter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic strobe_c
);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q;

  assign strobe_c = (cnt_q == LAST) && !clr;

  // Count 0..SETTLE-1 and wrap; held at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || clr)       cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps vec through every input combination of an
// N_VARS-input function in ascending order, holds each for SETTLE cycles,
// samples s on the last hold cycle and builds table_out / ones.
// Ports: clk, reset (sync, active-high), bus (truth_table_scanner_if.master:
//   start, s in; vec, busy, done, table_out, ones out).
// Optional: TRUTH_TABLE_SCANNER_COMPARE_EN adds expected/mismatch/pass.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned N_VARS = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_scanner_if.master bus
);
  localparam int unsigned ROWS = rows(N_VARS);
  localparam logic [N_VARS-1:0] VEC_MAX = '1;

  state_t            state_q, state_nxt;
  logic [N_VARS-1:0] vec_q, vec_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic [ROWS-1:0]   table_q, table_nxt;
  logic [N_VARS:0]   ones_q, ones_nxt;
  logic              settle_clr_c;
  logic              sample_c;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
  logic [ROWS-1:0]   exp_q, exp_nxt;
  logic [ROWS-1:0]   mismatch_q, mismatch_nxt;
  logic              pass_q, pass_nxt;
`endif

  assign settle_clr_c = (state_q != ST_SCAN);

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .clr      (settle_clr_c),
    .strobe_c (sample_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= '0;
      ones_q     <= '0;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
      exp_q      <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_nxt;
      vec_q      <= vec_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      table_q    <= table_nxt;
      ones_q     <= ones_nxt;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
      exp_q      <= exp_nxt;
      mismatch_q <= mismatch_nxt;
      pass_q     <= pass_nxt;
`endif
    end
  end

  // Next state and next output values.
  always_comb begin
    state_nxt    = state_q;
    vec_nxt      = vec_q;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;
    table_nxt    = table_q;
    ones_nxt     = ones_q;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    exp_nxt      = exp_q;
    mismatch_nxt = mismatch_q;
    pass_nxt     = pass_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_SCAN;
          vec_nxt   = '0;
          busy_nxt  = 1'b1;
          table_nxt = '0;
          ones_nxt  = '0;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
          exp_nxt      = bus.expected;
          mismatch_nxt = '0;
          pass_nxt     = 1'b0;
`endif
        end
      end
      ST_SCAN: begin
        if (sample_c) begin
          table_nxt[vec_q] = bus.s;
          ones_nxt         = ones_q + (N_VARS + 1)'(bus.s);
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
          mismatch_nxt[vec_q] = bus.s ^ exp_q[vec_q];
`endif
          // Last row ends the scan; vec never wraps past its maximum.
          if (vec_q == VEC_MAX) begin
            state_nxt = ST_DONE;
            vec_nxt   = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
            pass_nxt  = (mismatch_nxt == '0);
`endif
          end else begin
            vec_nxt = vec_q + N_VARS'(1);
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.vec       = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = table_q;
  assign bus.ones      = ones_q;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
  assign bus.mismatch  = mismatch_q;
  assign bus.pass      = pass_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) each
// driven by a table-lookup function; results compared against a row-by-row
// reference built from the function definition.
module tb_truth_table_scanner;

  logic clk;
  logic reset;
  logic [15:0] f1, f3;
  int sel;
  int n_checks, n_pass;

  truth_table_scanner_if #(.N_VARS(4)) if1 ();
  truth_table_scanner_if #(.N_VARS(4)) if3 ();

  truth_table_scanner #(.N_VARS(4), .SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  truth_table_scanner #(.N_VARS(4), .SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  assign if1.s = f1[if1.vec];
  assign if3.s = f3[if3.vec];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  vec_m;
  logic        busy_m, done_m;
  logic [15:0] tbl_m;
  logic [4:0]  ones_m;

  always_comb begin
    if (sel == 3) begin
      vec_m = if3.vec; busy_m = if3.busy; done_m = if3.done;
      tbl_m = if3.table_out; ones_m = if3.ones;
    end else begin
      vec_m = if1.vec; busy_m = if1.busy; done_m = if1.done;
      tbl_m = if1.table_out; ones_m = if1.ones;
    end
  end

  // Reference: bit i of the table is the function's value at input i.
  function automatic logic [15:0] ref_table(input logic [15:0] f);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[i] = f[i];
    return t;
  endfunction

  function automatic logic [4:0] ref_ones(input logic [15:0] f);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(f[i]);
    return 5'(n);
  endfunction

  task automatic drive_start(input int which, input logic v);
    if (which == 3) if3.start = v;
    else            if1.start = v;
  endtask

  // Runs one scan; records vec/busy ramp errors, done pulses and done timing.
  task automatic run_scan(input int which, input int restart_row,
                          output int ramp_err, output int done_cnt, output int done_at);
    int s_len;
    s_len = which;
    sel = which;
    ramp_err = 0; done_cnt = 0; done_at = -1;
    @(negedge clk); drive_start(which, 1'b1);
    @(negedge clk); drive_start(which, 1'b0);
    for (int m = 0; m < 16 * s_len + 6; m++) begin
      if (m < 16 * s_len) begin
        if (vec_m !== 4'(m / s_len) || busy_m !== 1'b1) ramp_err++;
      end else if (vec_m !== 4'd0 || busy_m !== 1'b0) ramp_err++;
      if (done_m === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = m;
      end
      drive_start(which, (m == restart_row * s_len) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    drive_start(which, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    sel = 1;
    #1;
    n_checks++; if (vec_m !== 4'd0) $display("FAIL reset_vec: got %h want 0", vec_m); else n_pass++;
    n_checks++; if (busy_m !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_m); else n_pass++;
    n_checks++; if (done_m !== 1'b0) $display("FAIL reset_done: got %b want 0", done_m); else n_pass++;
    n_checks++; if (tbl_m !== 16'h0) $display("FAIL reset_table: got %h want 0", tbl_m); else n_pass++;
    n_checks++; if (ones_m !== 5'd0) $display("FAIL reset_ones: got %0d want 0", ones_m); else n_pass++;
    n_checks++; if (if3.busy !== 1'b0) $display("FAIL reset_busy3: got %b want 0", if3.busy); else n_pass++;
  endtask

  task automatic test_function(input string name, input int which, input logic [15:0] f,
                               input logic [15:0] want_tbl, input logic [4:0] want_ones);
    int re, dc, da;
    if (which == 3) f3 = f; else f1 = f;
    run_scan(which, -1, re, dc, da);
    sel = which;
    n_checks++; if (re !== 0) $display("FAIL %s_ramp: got %0d errors want 0", name, re); else n_pass++;
    n_checks++; if (dc !== 1) $display("FAIL %s_done_cnt: got %0d want 1", name, dc); else n_pass++;
    n_checks++; if (da !== 16 * which) $display("FAIL %s_latency: got %0d want %0d", name, da, 16 * which); else n_pass++;
    n_checks++; if (tbl_m !== want_tbl) $display("FAIL %s_table: got %h want %h", name, tbl_m, want_tbl); else n_pass++;
    n_checks++; if (ones_m !== want_ones) $display("FAIL %s_ones: got %0d want %0d", name, ones_m, want_ones); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] f;
    for (int k = 0; k < 4; k++) begin
      f = 16'($urandom);
      test_function("rand1", 1, f, ref_table(f), ref_ones(f));
    end
    for (int k = 0; k < 2; k++) begin
      f = 16'($urandom);
      test_function("rand3", 3, f, ref_table(f), ref_ones(f));
    end
  endtask

  task automatic test_restart();
    int re, dc, da;
    logic [15:0] f;
    f = 16'($urandom);
    f1 = f;
    run_scan(1, 7, re, dc, da);
    sel = 1;
    n_checks++; if (re !== 0) $display("FAIL restart_ramp: got %0d errors want 0", re); else n_pass++;
    n_checks++; if (dc !== 1) $display("FAIL restart_done_cnt: got %0d want 1", dc); else n_pass++;
    n_checks++; if (da !== 16) $display("FAIL restart_latency: got %0d want 16", da); else n_pass++;
    n_checks++; if (tbl_m !== ref_table(f)) $display("FAIL restart_table: got %h want %h", tbl_m, ref_table(f)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    sel = 1;
    f1 = 16'hFFFF;
    @(negedge clk); if1.start = 1'b1;
    @(negedge clk); if1.start = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++; if (vec_m !== 4'd9) $display("FAIL midreset_row: got %0d want 9", vec_m); else n_pass++;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_checks++; if (vec_m !== 4'd0) $display("FAIL midreset_vec: got %h want 0", vec_m); else n_pass++;
    n_checks++; if (busy_m !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy_m); else n_pass++;
    n_checks++; if (tbl_m !== 16'h0) $display("FAIL midreset_table: got %h want 0", tbl_m); else n_pass++;
    n_checks++; if (ones_m !== 5'd0) $display("FAIL midreset_ones: got %0d want 0", ones_m); else n_pass++;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_m !== 1'b0 || busy_m !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL midreset_quiet: got %0d active cycles want 0", bad); else n_pass++;
    reset = 1'b1; if1.start = 1'b1;
    @(negedge clk); reset = 1'b0; if1.start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_m !== 1'b0) $display("FAIL reset_priority: got busy %b want 0", busy_m); else n_pass++;
  endtask

`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
  task automatic test_compare();
    int re, dc, da;
    logic [15:0] f, e;
    f1 = 16'h212F; if1.expected = 16'h212F;
    run_scan(1, -1, re, dc, da);
    n_checks++; if (if1.pass !== 1'b1) $display("FAIL cmp_pass_match: got %b want 1", if1.pass); else n_pass++;
    n_checks++; if (if1.mismatch !== 16'h0) $display("FAIL cmp_mm_match: got %h want 0", if1.mismatch); else n_pass++;
    if1.expected = 16'h212E;
    run_scan(1, -1, re, dc, da);
    n_checks++; if (if1.pass !== 1'b0) $display("FAIL cmp_pass_diff: got %b want 0", if1.pass); else n_pass++;
    n_checks++; if (if1.mismatch !== 16'h0001) $display("FAIL cmp_mm_diff: got %h want 0001", if1.mismatch); else n_pass++;
    f = 16'($urandom); e = 16'($urandom);
    f3 = f; if3.expected = e;
    run_scan(3, -1, re, dc, da);
    n_checks++; if (if3.mismatch !== (ref_table(f) ^ e)) $display("FAIL cmp_mm_rand: got %h want %h", if3.mismatch, ref_table(f) ^ e); else n_pass++;
    n_checks++; if (if3.pass !== (ref_table(f) == e)) $display("FAIL cmp_pass_rand: got %b want %b", if3.pass, ref_table(f) == e); else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0; n_pass = 0;
    sel = 1;
    reset = 1'b1;
    if1.start = 1'b0; if3.start = 1'b0;
    f1 = '0; f3 = '0;
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    if1.expected = '0; if3.expected = '0;
`endif
    test_reset();
    test_function("pos", 1, 16'h212F, 16'h212F, 5'd7);
    test_function("and4", 1, 16'h8000, 16'h8000, 5'd1);
    test_function("all1", 1, 16'hFFFF, 16'hFFFF, 5'd16);
    test_function("and4_s3", 3, 16'h8000, 16'h8000, 5'd1);
    test_random();
    test_restart();
    test_reset_mid();
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    test_compare();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
